frame_ram_arbiter: RTL and testbench

//  Single-clock arbiter sharing one single-port RGB565 frame RAM between the SD-load write stream and the VGA scan read stream.

---
 rtl/frame_ram_arbiter_pkg.sv | 14 +
 rtl/frame_ram_arbiter_if.sv | 36 +++
 rtl/frame_ram_arbiter_wr_skid_fifo.sv | 36 +++
 rtl/frame_ram_arbiter.sv | 101 ++++++++++
 tb/tb_frame_ram_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/frame_ram_arbiter_pkg.sv
// Shared types and defaults for the frame RAM arbiter: geometry, grant encoding,
// and a range-check helper used on both request paths.
package frame_ram_pkg;
    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 16;
    localparam int IMAGE_SIZE = 76800;
    localparam int FB_DEPTH   = IMAGE_SIZE;

    typedef enum logic [1:0] {GNT_NONE, GNT_RD, GNT_WR} grant_e;

    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] depth);
        return addr < depth;
    endfunction
endpackage

// File: rtl/frame_ram_arbiter_if.sv
// Bus bundle between the load/scan clients, the frame RAM and the arbiter.
// slave = arbiter side, master = everything around it.
interface frame_ram_arbiter_if
    import frame_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              err_addr;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_rdata,
        output wr_ready, rd_ready, rd_valid, rd_data,
               ram_en, ram_we, ram_addr, ram_wdata, err_addr
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_rdata,
        input  wr_ready, rd_ready, rd_valid, rd_data,
               ram_en, ram_we, ram_addr, ram_wdata, err_addr
    );
endinterface

// File: rtl/frame_ram_arbiter_wr_skid_fifo.sv
// Two-entry write buffer. The caller only pushes when count_o < 2 and only
// pops when count_o != 0, so no internal overflow guarding is needed.
module wr_skid_fifo #(
    parameter int W = 33
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wptr_q, rptr_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_i) wptr_q <= ~wptr_q;
            if (pop_i)  rptr_q <= ~rptr_q;
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= din_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/frame_ram_arbiter.sv
// Shares one single-port frame RAM between the SD-load write stream and the VGA
// read stream. Reads win unless a queued write has waited MAX_WR_WAIT cycles.
module frame_ram_arbiter
    import frame_ram_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FB_DEPTH    = IMAGE_SIZE,
    parameter int RAM_LATENCY = 1,
    parameter int MAX_WR_WAIT = 4
) (
    input  logic                clk_100MHz,
    input  logic                rst,
    frame_ram_arbiter_if.slave  bus
);
    localparam int SW = $clog2(MAX_WR_WAIT + 1);

    logic [ADDR_W+DATA_W-1:0] fifo_head;
    logic [1:0]               fifo_cnt;
    logic                     fifo_ne, force_wr, wr_push, wr_inr, rd_inr, rd_acc;
    grant_e                   gnt;
    logic [SW-1:0]            starve_q, starve_d;

    logic                     ram_en_q, ram_we_q, err_q, rd_valid_q;
    logic [ADDR_W-1:0]        ram_addr_q;
    logic [DATA_W-1:0]        ram_wdata_q, rd_data_q;
    logic [RAM_LATENCY:0]     vld_pipe_q, oor_pipe_q;

    assign fifo_ne  = (fifo_cnt != 2'd0);
    assign force_wr = fifo_ne && (starve_q == SW'(MAX_WR_WAIT));
    assign wr_inr   = in_range(32'(bus.wr_addr), 32'(FB_DEPTH));
    assign rd_inr   = in_range(32'(bus.rd_addr), 32'(FB_DEPTH));
    assign wr_push  = bus.wr_req & bus.wr_ready;
    assign rd_acc   = (gnt == GNT_RD);

    // Out-of-range writes complete the handshake but never enter the queue.
    wr_skid_fifo #(.W(ADDR_W + DATA_W)) u_wr_fifo (
        .clk_i   (clk_100MHz),
        .rst_i   (rst),
        .push_i  (wr_push & wr_inr),
        .pop_i   (gnt == GNT_WR),
        .din_i   ({bus.wr_addr, bus.wr_data}),
        .head_o  (fifo_head),
        .count_o (fifo_cnt)
    );

    always_comb begin
        gnt = GNT_NONE;
        if (force_wr)        gnt = GNT_WR;
        else if (bus.rd_req) gnt = GNT_RD;
        else if (fifo_ne)    gnt = GNT_WR;
    end

    always_comb begin
        starve_d = '0;
        if (fifo_ne && gnt != GNT_WR)
            starve_d = (starve_q == SW'(MAX_WR_WAIT)) ? starve_q : starve_q + SW'(1);
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            starve_q    <= '0;
            err_q       <= 1'b0;
            vld_pipe_q  <= '0;
            oor_pipe_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            ram_en_q <= (gnt == GNT_WR) || (rd_acc && rd_inr);
            ram_we_q <= (gnt == GNT_WR);
            if (gnt == GNT_WR) begin
                ram_addr_q  <= fifo_head[ADDR_W+DATA_W-1 -: ADDR_W];
                ram_wdata_q <= fifo_head[DATA_W-1:0];
            end else if (rd_acc && rd_inr) begin
                ram_addr_q  <= bus.rd_addr;
            end
            starve_q   <= starve_d;
            err_q      <= err_q | (wr_push & ~wr_inr) | (rd_acc & ~rd_inr);
            // Out-of-range reads ride the same pipe so they return in order with zero data.
            vld_pipe_q <= {vld_pipe_q[RAM_LATENCY-1:0], rd_acc};
            oor_pipe_q <= {oor_pipe_q[RAM_LATENCY-1:0], ~rd_inr};
            rd_valid_q <= vld_pipe_q[RAM_LATENCY];
            if (vld_pipe_q[RAM_LATENCY])
                rd_data_q <= oor_pipe_q[RAM_LATENCY] ? '0 : bus.ram_rdata;
        end
    end

    assign bus.wr_ready  = (fifo_cnt < 2'd2);
    assign bus.rd_ready  = ~force_wr;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.err_addr  = err_q;
endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed bench for frame_ram_arbiter with a 1-cycle-latency RAM model whose
// word i initially holds i.
module tb_frame_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_ram_arbiter_if #(.ADDR_W(17), .DATA_W(16)) bus();

    frame_ram_arbiter #(
        .ADDR_W(17), .DATA_W(16), .FB_DEPTH(76800), .RAM_LATENCY(1), .MAX_WR_WAIT(4)
    ) dut (
        .clk_100MHz (clk),
        .rst        (rst),
        .bus        (bus)
    );

    logic [15:0] mem [1024];
    int checks = 0;
    int errors = 0;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
        bus.ram_rdata = '0;
    end

    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr[9:0]] <= bus.ram_wdata;
            else            bus.ram_rdata <= mem[bus.ram_addr[9:0]];
        end
    end

    task automatic idle();
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++; if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.rd_valid, bus.rd_data, bus.err_addr} !== '0) begin
            errors++; $display("FAIL por_outputs: got %h expected 0", {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.rd_valid, bus.rd_data, bus.err_addr}); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL por_wr_ready: got %b expected 1", bus.wr_ready); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        bus.wr_req = 1'b1; bus.wr_addr = 17'd10; bus.wr_data = 16'hAAAA;
        bus.rd_req = 1'b1; bus.rd_addr = 17'd20;
        @(negedge clk);
        bus.wr_addr = 17'd11; bus.wr_data = 16'hBBBB; bus.rd_addr = 17'd21;
        @(negedge clk);
        idle(); #1;
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL mid_two_queued: wr_ready got %b expected 0", bus.wr_ready); end
        rst = 1'b1; #1;
        checks++; if (bus.ram_en !== 1'b0 || bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL mid_rst_outputs: ram_en=%b rd_valid=%b expected 0 0", bus.ram_en, bus.rd_valid); end
        checks++; if (bus.wr_ready !== 1'b1 || bus.err_addr !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ready_err: wr_ready=%b err=%b expected 1 0", bus.wr_ready, bus.err_addr); end
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            checks++; if (bus.ram_en !== 1'b0 || bus.rd_valid !== 1'b0) begin
                errors++; $display("FAIL post_rst_quiet c=%0d: ram_en=%b rd_valid=%b expected 0 0", c, bus.ram_en, bus.rd_valid); end
        end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL post_rst_wr_ready: got %b expected 1", bus.wr_ready); end
    endtask

    task automatic test_read_stream();
        logic exp_v;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            exp_v = (c >= 3 && c <= 12);
            checks++; if (bus.rd_valid !== exp_v) begin errors++; $display("FAIL rs_valid c=%0d: got %b expected %b", c, bus.rd_valid, exp_v); end
            if (exp_v) begin
                checks++; if (bus.rd_data !== 16'(c - 3)) begin errors++; $display("FAIL rs_data c=%0d: got %0d expected %0d", c, bus.rd_data, c - 3); end
            end
            bus.rd_req = (c < 10); bus.rd_addr = 17'(c);
            #1;
            if (c < 10) begin
                checks++; if (bus.rd_ready !== 1'b1) begin errors++; $display("FAIL rs_ready c=%0d: got %b expected 1", c, bus.rd_ready); end
            end
        end
        idle();
    endtask

    task automatic test_starvation();
        int denied = 0;
        @(negedge clk);
        bus.rd_req = 1'b1; bus.rd_addr = 17'd400;
        bus.wr_req = 1'b1; bus.wr_addr = 17'd5; bus.wr_data = 16'hF800;
        #1;
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL st_wr_ready: got %b expected 1", bus.wr_ready); end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.wr_req = 1'b0;
            #1;
            if (bus.rd_ready === 1'b0) denied++;
            checks++; if (bus.rd_ready !== (c != 5)) begin errors++; $display("FAIL st_rd_ready c=%0d: got %b expected %b", c, bus.rd_ready, (c != 5)); end
            checks++; if (bus.ram_we !== (c == 6)) begin errors++; $display("FAIL st_ram_we c=%0d: got %b expected %b", c, bus.ram_we, (c == 6)); end
            if (c == 6) begin
                checks++; if (bus.ram_addr !== 17'd5 || bus.ram_wdata !== 16'hF800) begin
                    errors++; $display("FAIL st_write: addr=%0d data=%h expected 5 f800", bus.ram_addr, bus.ram_wdata); end
            end
        end
        checks++; if (denied != 1) begin errors++; $display("FAIL st_denied_once: got %0d expected 1", denied); end
        idle();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_fifo_full();
        int idx = 0;
        int nw = 0;
        logic [16:0] wa [3];
        logic [15:0] wd [3];
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.ram_en && bus.ram_we) begin
                if (nw < 3) begin wa[nw] = bus.ram_addr; wd[nw] = bus.ram_wdata; end
                nw++;
            end
            bus.rd_req  = 1'b1; bus.rd_addr = 17'(500 + c);
            bus.wr_req  = (idx < 3);
            bus.wr_addr = 17'(300 + idx);
            bus.wr_data = 16'(16'h1111 * (idx + 1));
            #1;
            if (c == 2) begin
                checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL ff_wr_ready_full: got %b expected 0", bus.wr_ready); end
            end
            if (bus.wr_req && bus.wr_ready) idx++;
        end
        idle();
        checks++; if (idx != 3) begin errors++; $display("FAIL ff_accepted: got %0d expected 3", idx); end
        checks++; if (nw != 3) begin errors++; $display("FAIL ff_ram_writes: got %0d expected 3", nw); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (wa[i] !== 17'(300 + i) || wd[i] !== 16'(16'h1111 * (i + 1))) begin
                errors++; $display("FAIL ff_order i=%0d: addr=%0d data=%h expected %0d %h", i, wa[i], wd[i], 300 + i, 16'(16'h1111 * (i + 1))); end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_idle_drain();
        @(negedge clk);
        bus.wr_req = 1'b1; bus.wr_addr = 17'd100; bus.wr_data = 16'h0A0A;
        @(negedge clk);
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL dr_no_bypass: ram_we got %b expected 0", bus.ram_we); end
        bus.wr_addr = 17'd101; bus.wr_data = 16'h0B0B;
        @(negedge clk);
        idle();
        checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 17'd100 || bus.ram_wdata !== 16'h0A0A) begin
            errors++; $display("FAIL dr_first: we=%b addr=%0d data=%h expected 1 100 0a0a", bus.ram_we, bus.ram_addr, bus.ram_wdata); end
        @(negedge clk);
        checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 17'd101 || bus.ram_wdata !== 16'h0B0B) begin
            errors++; $display("FAIL dr_second: we=%b addr=%0d data=%h expected 1 101 0b0b", bus.ram_we, bus.ram_addr, bus.ram_wdata); end
        @(negedge clk);
        checks++; if (bus.ram_en !== 1'b0) begin errors++; $display("FAIL dr_idle: ram_en got %b expected 0", bus.ram_en); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_range();
        @(negedge clk);
        checks++; if (bus.err_addr !== 1'b0) begin errors++; $display("FAIL rg_err_before: got %b expected 0", bus.err_addr); end
        checks++; if (bus.rd_data === 16'h0000) begin errors++; $display("FAIL rg_precond: rd_data got %h expected nonzero", bus.rd_data); end
        bus.wr_req = 1'b1; bus.wr_addr = 17'd76800; bus.wr_data = 16'h1234;
        #1;
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL rg_wr_ready: got %b expected 1", bus.wr_ready); end
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            checks++; if (bus.ram_en !== 1'b0) begin errors++; $display("FAIL rg_ram_en c=%0d: got %b expected 0", c, bus.ram_en); end
            checks++; if (bus.err_addr !== 1'b1) begin errors++; $display("FAIL rg_err c=%0d: got %b expected 1", c, bus.err_addr); end
            checks++; if (bus.rd_valid !== (c == 4)) begin errors++; $display("FAIL rg_valid c=%0d: got %b expected %b", c, bus.rd_valid, (c == 4)); end
            if (c == 4) begin
                checks++; if (bus.rd_data !== 16'h0000) begin errors++; $display("FAIL rg_rd_data: got %h expected 0", bus.rd_data); end
            end
            if (c == 1) begin
                bus.wr_req = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 17'd76801;
                #1;
                checks++; if (bus.rd_ready !== 1'b1) begin errors++; $display("FAIL rg_rd_ready: got %b expected 1", bus.rd_ready); end
            end else begin
                idle();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        test_reset();
        test_read_stream();
        test_starvation();
        test_fifo_full();
        test_idle_drain();
        test_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
